// File: rtl/aes_round_ctrl.sv
// aes_round_ctrl: AES-128 encryption round sequencer (load, ARK0, NR x SB/SR/MC/ARK, done).
module aes_round_ctrl #(
  parameter int NR = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_i,
  input  logic       hold_i,
  input  logic       abort_i,
  output logic       busy_o,
  output logic       done_o,
  output logic       load_o,
  output logic       sb_en_o,
  output logic       sr_en_o,
  output logic       mc_en_o,
  output logic       ark_en_o,
  output logic       key_step_o,
  output logic [3:0] round_o,
  output logic [7:0] rcon_o
);
  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] LOAD = 3'd1;
  localparam logic [2:0] ARK0 = 3'd2;
  localparam logic [2:0] SB   = 3'd3;
  localparam logic [2:0] SR   = 3'd4;
  localparam logic [2:0] MC   = 3'd5;
  localparam logic [2:0] ARK  = 3'd6;
  localparam logic [2:0] DONE = 3'd7;
  localparam logic [3:0] LAST = 4'(NR);
  logic [2:0] state, state_nxt;
  logic [3:0] round, round_nxt;
  logic       act;
  always_comb begin
    state_nxt = state;
    round_nxt = round;
    case (state)
      IDLE: state_nxt = start_i ? LOAD : IDLE;
      LOAD: begin
        state_nxt = ARK0;
        round_nxt = 4'd0;
      end
      ARK0: begin
        state_nxt = SB;
        round_nxt = 4'd1;
      end
      SB:  state_nxt = SR;
      SR:  state_nxt = (round == LAST) ? ARK : MC;
      MC:  state_nxt = ARK;
      ARK: begin
        state_nxt = (round < LAST) ? SB : DONE;
        round_nxt = (round < LAST) ? round + 4'd1 : round;
      end
      default: begin
        state_nxt = IDLE;
        round_nxt = 4'd0;
      end
    endcase
    if (hold_i) begin
      state_nxt = state;
      round_nxt = round;
    end
    if (abort_i) begin
      state_nxt = IDLE;
      round_nxt = 4'd0;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      round <= 4'd0;
    end else begin
      state <= state_nxt;
      round <= round_nxt;
    end
  end
  // a held sequencer drives no datapath strobes at all
  assign act        = !hold_i;
  assign busy_o     = state != IDLE;
  assign done_o     = act && state == DONE;
  assign load_o     = act && state == LOAD;
  assign ark_en_o   = act && (state == ARK0 || state == ARK);
  assign sb_en_o    = act && state == SB;
  assign sr_en_o    = act && state == SR;
  assign mc_en_o    = act && state == MC;
  assign key_step_o = act && state == SR;
  assign round_o    = round;
  always_comb begin
    case (round)
      4'd1:    rcon_o = 8'h01;
      4'd2:    rcon_o = 8'h02;
      4'd3:    rcon_o = 8'h04;
      4'd4:    rcon_o = 8'h08;
      4'd5:    rcon_o = 8'h10;
      4'd6:    rcon_o = 8'h20;
      4'd7:    rcon_o = 8'h40;
      4'd8:    rcon_o = 8'h80;
      4'd9:    rcon_o = 8'h1b;
      4'd10:   rcon_o = 8'h36;
      default: rcon_o = 8'h00;
    endcase
  end
endmodule

// File: tb/tb_aes_round_ctrl.sv
// tb_aes_round_ctrl: table-driven check of the round sequencer, NR=10 and NR=1 builds side by side.
module tb_aes_round_ctrl;
  logic clk = 1'b0, rst = 1'b1, start_i = 1'b0, hold_i = 1'b0, abort_i = 1'b0;
  logic busy, done, load, sb, sr, mc, ark, ks;
  logic busy1, done1, load1, sb1, sr1, mc1, ark1, ks1;
  logic [3:0] rnd, rnd1;
  logic [7:0] rcon, rcon1;
  always #5 clk = ~clk;
  aes_round_ctrl #(.NR(10)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .hold_i(hold_i), .abort_i(abort_i),
    .busy_o(busy), .done_o(done), .load_o(load), .sb_en_o(sb), .sr_en_o(sr),
    .mc_en_o(mc), .ark_en_o(ark), .key_step_o(ks), .round_o(rnd), .rcon_o(rcon)
  );
  aes_round_ctrl #(.NR(1)) dut1 (
    .clk(clk), .rst(rst), .start_i(start_i), .hold_i(hold_i), .abort_i(abort_i),
    .busy_o(busy1), .done_o(done1), .load_o(load1), .sb_en_o(sb1), .sr_en_o(sr1),
    .mc_en_o(mc1), .ark_en_o(ark1), .key_step_o(ks1), .round_o(rnd1), .rcon_o(rcon1)
  );
  // observation word: {busy,done,load,ark,sb,sr,mc,ks, round[3:0], rcon[7:0]}
  wire [19:0] pk  = {busy, done, load, ark, sb, sr, mc, ks, rnd, rcon};
  wire [19:0] pk1 = {busy1, done1, load1, ark1, sb1, sr1, mc1, ks1, rnd1, rcon1};
  typedef struct {
    int n, s1, s2, s3, h0, hl, ab, rc;
    int done_cnt, done_cyc, mc_cnt, ks_cnt;
  } sc_t;
  typedef struct {
    int scen, inst, cyc;
    logic [7:0] fl;
    int r;
  } pt_t;
  sc_t sc[6];
  pt_t pts[$];
  logic [7:0] rct[0:10];
  logic [19:0] obs[0:99], obs1[0:99];
  int n_chk = 0, n_fail = 0;
  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask
  function automatic logic [19:0] ex(input logic [7:0] fl, input int r);
    return {fl, 4'(r), rct[r]};
  endfunction
  task automatic add(input int s, input int i, input int c, input logic [7:0] fl, input int r);
    pt_t p;
    p.scen = s; p.inst = i; p.cyc = c; p.fl = fl; p.r = r;
    pts.push_back(p);
  endtask
  task automatic run(input sc_t s);
    for (int c = 0; c <= s.n; c++) begin
      @(posedge clk);
      #1;
      start_i = (c == s.s1 || c == s.s2 || c == s.s3);
      hold_i  = (c >= s.h0 && c < s.h0 + s.hl);
      abort_i = (c == s.ab);
      if (c == s.rc) begin
        #2 rst = 1'b1;
        #1 chk("async_rst", {12'd0, pk}, 32'd0);
      end
      @(negedge clk);
      obs[c] = pk;
      obs1[c] = pk1;
      if (c == s.rc) #1 rst = 1'b0;
    end
    start_i = 1'b0;
    hold_i = 1'b0;
    abort_i = 1'b0;
  endtask
  initial begin
    rct = '{8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
    //            n  s1  s2  s3  h0  hl  ab  rc  dcnt dcyc mc  ks
    sc[0] = '{46,  0, -1, -1, -1,  0, -1, -1,  1,  42,  9, 10};
    sc[1] = '{50,  0, -1, -1, 16,  5, -1, -1,  1,  47,  9, 10};
    sc[2] = '{80,  0, 30, -1, -1,  0, 25, -1,  1,  72, 15, 16};
    sc[3] = '{46,  0, 10, 42, -1,  0, -1, -1,  1,  42,  9, 10};
    sc[4] = '{46,  0, -1, -1, -1,  0,  0, -1,  0,  -1,  0,  0};
    sc[5] = '{70,  0, 20, -1, -1,  0, -1, 12,  1,  62, 11, 12};
    add(0, 0,  0, 8'b0000_0000,  0);
    add(0, 0,  1, 8'b1010_0000,  0);
    add(0, 0,  2, 8'b1001_0000,  0);
    add(0, 0,  3, 8'b1000_1000,  1);
    add(0, 0,  4, 8'b1000_0101,  1);
    add(0, 0,  5, 8'b1000_0010,  1);
    add(0, 0,  6, 8'b1001_0000,  1);
    add(0, 0, 39, 8'b1000_1000, 10);
    add(0, 0, 40, 8'b1000_0101, 10);
    add(0, 0, 41, 8'b1001_0000, 10);
    add(0, 0, 42, 8'b1100_0000, 10);
    add(0, 0, 43, 8'b0000_0000,  0);
    add(0, 1,  2, 8'b1001_0000,  0);
    add(0, 1,  3, 8'b1000_1000,  1);
    add(0, 1,  4, 8'b1000_0101,  1);
    add(0, 1,  5, 8'b1001_0000,  1);
    add(0, 1,  6, 8'b1100_0000,  1);
    add(0, 1,  7, 8'b0000_0000,  0);
    add(1, 0, 16, 8'b1000_0000,  4);
    add(1, 0, 20, 8'b1000_0000,  4);
    add(1, 0, 21, 8'b1000_0101,  4);
    add(1, 0, 47, 8'b1100_0000, 10);
    add(2, 0, 25, 8'b1000_0010,  6);
    add(2, 0, 26, 8'b0000_0000,  0);
    add(2, 0, 31, 8'b1010_0000,  0);
    add(3, 0, 11, 8'b1000_1000,  3);
    add(3, 0, 43, 8'b0000_0000,  0);
    add(3, 0, 44, 8'b0000_0000,  0);
    add(4, 0,  1, 8'b0000_0000,  0);
    add(5, 0, 12, 8'b0000_0000,  0);
    add(5, 0, 13, 8'b0000_0000,  0);
    add(5, 0, 21, 8'b1010_0000,  0);
    add(5, 0, 62, 8'b1100_0000, 10);
    #1;
    chk("reset_out", {12'd0, pk}, 32'd0);
    chk("reset_out_nr1", {12'd0, pk1}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int s = 0; s < 6; s++) begin
      int dcnt, dcyc, mcc, ksc, sr4, mc1c;
      logic [7:0] seq[$];
      run(sc[s]);
      dcnt = 0; dcyc = -1; mcc = 0; ksc = 0; sr4 = 0; mc1c = 0;
      for (int c = 0; c <= sc[s].n; c++) begin
        if (obs[c][18]) begin
          dcnt++;
          if (dcyc < 0) dcyc = c;
        end
        mcc += int'(obs[c][13]);
        ksc += int'(obs[c][12]);
        mc1c += int'(obs1[c][13]);
        if (obs[c][14] && obs[c][11:8] == 4'd4) sr4++;
        if (obs[c][15]) seq.push_back(obs[c][7:0]);
      end
      chk($sformatf("s%0d_done_cnt", s), dcnt, sc[s].done_cnt);
      chk($sformatf("s%0d_done_cyc", s), dcyc, sc[s].done_cyc);
      chk($sformatf("s%0d_mc_cnt", s), mcc, sc[s].mc_cnt);
      chk($sformatf("s%0d_ks_cnt", s), ksc, sc[s].ks_cnt);
      if (s == 0) begin
        chk("nr1_mc_cnt", mc1c, 0);
        chk("rcon_seq_len", seq.size(), 10);
        for (int i = 0; i < seq.size() && i < 10; i++)
          chk($sformatf("rcon_r%0d", i + 1), {24'd0, seq[i]}, {24'd0, rct[i + 1]});
      end
      if (s == 1) chk("stall_sr4_cnt", sr4, 1);
      foreach (pts[i])
        if (pts[i].scen == s)
          chk($sformatf("s%0d_i%0d_c%0d", s, pts[i].inst, pts[i].cyc),
              {12'd0, pts[i].inst ? obs1[pts[i].cyc] : obs[pts[i].cyc]},
              {12'd0, ex(pts[i].fl, pts[i].r)});
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/aes_round_ctrl.md
AES_ROUND_CTRL -- requirements
Module: aes_round_ctrl

Interface
REQ-001 Parameter: NR, default 10, number of cipher rounds; legal range 1..10.
REQ-002 Port: clk, input, 1, single clock; all state updates on the rising edge.
REQ-003 Port: rst, input, 1, asynchronous active-high reset.
REQ-004 Port: start_i, input, 1, request to begin one block encryption; sampled in IDLE only.
REQ-005 Port: hold_i, input, 1, stall; freezes the sequencer while high.
REQ-006 Port: abort_i, input, 1, cancels the operation in progress.
REQ-007 Port: busy_o, output, 1, high in every state except IDLE.
REQ-008 Port: done_o, output, 1, one-cycle pulse when the final AddRoundKey has completed.
REQ-009 Port: load_o, output, 1, selects plaintext and the cipher key into the state and key registers.
REQ-010 Port: sb_en_o / sr_en_o / mc_en_o / ark_en_o, output, 1 each, enable for the SubBytes, ShiftRows, MixColumns and AddRoundKey stages respectively.
REQ-011 Port: key_step_o, output, 1, advances key expansion by one round key.
REQ-012 Port: round_o, output, 4, current round number (0 during LOAD/ARK0).
REQ-013 Port: rcon_o, output, 8, round constant for round_o.

Function
REQ-014 The states SHALL be IDLE, LOAD, ARK0, SB, SR, MC, ARK and DONE; each non-IDLE state lasts exactly one unstalled cycle.
REQ-015 IDLE SHALL go to LOAD on start_i=1; otherwise IDLE SHALL hold.
REQ-016 The sequence SHALL be LOAD -> ARK0 -> SB -> SR -> MC -> ARK; after ARK, the sequencer SHALL go to SB with round+1 if round<NR, else to DONE.
REQ-017 When round==NR, SR SHALL go directly to ARK, so MC is skipped in the final round.
REQ-018 DONE SHALL go to IDLE unconditionally; start_i asserted in DONE SHALL be ignored.
REQ-019 The round counter SHALL clear to 0 in LOAD, become 1 on the ARK0->SB transition, and increment on each ARK->SB transition.
REQ-020 Stage enables SHALL be one-hot and combinational from state: load_o in LOAD, ark_en_o in ARK0 and ARK, sb_en_o in SB, sr_en_o in SR, mc_en_o in MC; all SHALL be 0 in IDLE and DONE.
REQ-021 key_step_o SHALL be high in each SR state, so the round key is ready before that round's ARK.
REQ-022 rcon_o SHALL follow round_o: rounds 1..10 -> 01,02,04,08,10,20,40,80,1B,36; round 0 -> 00.
REQ-023 Latency: with start_i sampled at edge 0 and no stall, done_o SHALL be high during cycle 4*NR+2 (cycle 42 for NR=10).
REQ-024 start_i SHALL be ignored while busy_o=1.
REQ-025 While hold_i=1, state and round SHALL be frozen and all enables, key_step_o and done_o SHALL be forced to 0; busy_o SHALL stay 1; the sequence SHALL resume on the cycle after hold_i deasserts.
REQ-026 abort_i=1 SHALL force IDLE at the next edge with round=0 and no done_o pulse.
REQ-027 abort_i SHALL take priority over hold_i and start_i.
REQ-028 abort_i asserted in IDLE SHALL keep the sequencer in IDLE even if start_i=1 in the same cycle.

Reset
REQ-029 rst=1 SHALL immediately force IDLE, round_o=0, busy_o=0 and done_o=0, and SHALL drive all enables, key_step_o and rcon_o to 0, independent of clk.
REQ-030 Reset asserted mid-operation SHALL discard the operation; no done_o SHALL follow reset release.
REQ-031 The first start_i after reset release SHALL be accepted normally.

Verification
REQ-032 Nominal: start_i pulse at edge 0, NR=10 -> load_o in cycle 1, ark_en_o in cycle 2, sb_en_o in cycle 3; mc_en_o pulses 9 times; done_o in cycle 42 only; busy_o falls in cycle 43.
REQ-033 Round constants: sample rcon_o at each sb_en_o -> 01,02,04,08,10,20,40,80,1B,36 in order; key_step_o count = 10.
REQ-034 Stall: hold_i=1 for 5 cycles during round 4 SR -> done_o delayed to cycle 47; no enable high while held; exactly one sr_en_o for round 4.
REQ-035 Abort: abort_i in round 6 MC -> IDLE next cycle, busy_o=0, no done_o; a new start_i then gives done_o exactly 42 cycles later.
REQ-036 Start while busy and in DONE: start_i pulses at cycles 10 and 42 -> ignored, only one done_o, IDLE at cycle 43.
REQ-037 Async reset: rst pulsed mid-cycle during round 3 -> outputs 0 before the next clk edge; no done_o after release; NR=1 build -> ARK0, SB, SR, ARK (no MC), done_o in cycle 6.
